// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register: captures execute-stage results and MEM/WB controls,
// with synchronous reset, flush (bubble) and stall (hold) for the hazard unit.
module ex_mem_pipe_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_W   = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              EX_regwrite,
    input  logic              EX_memtoreg,
    input  logic              EX_memread,
    input  logic              EX_memwrite,
    input  logic              EX_in2_mux,
    input  logic [DATA_W-1:0] EX_out,
    input  logic [DATA_W-1:0] EX_wdata,
    input  logic [RD_W-1:0]   EX_rd,
    output logic              MEM_regwrite,
    output logic              MEM_memtoreg,
    output logic              MEM_memread,
    output logic              MEM_memwrite,
    output logic              MEM_in2_mux,
    output logic [DATA_W-1:0] MEM_out,
    output logic [DATA_W-1:0] MEM_wdata,
    output logic [RD_W-1:0]   MEM_rd
);

    logic              regwrite_q, regwrite_d;
    logic              memtoreg_q, memtoreg_d;
    logic              memread_q,  memread_d;
    logic              memwrite_q, memwrite_d;
    logic              in2_mux_q,  in2_mux_d;
    logic [DATA_W-1:0] out_q,      out_d;
    logic [DATA_W-1:0] wdata_q,    wdata_d;
    logic [RD_W-1:0]   rd_q,       rd_d;

    // Flush beats stall so a bubble can be inserted while upstream is frozen.
    always_comb begin
        regwrite_d = regwrite_q;
        memtoreg_d = memtoreg_q;
        memread_d  = memread_q;
        memwrite_d = memwrite_q;
        in2_mux_d  = in2_mux_q;
        out_d      = out_q;
        wdata_d    = wdata_q;
        rd_d       = rd_q;
        if (flush) begin
            regwrite_d = 1'b0;
            memtoreg_d = 1'b0;
            memread_d  = 1'b0;
            memwrite_d = 1'b0;
            in2_mux_d  = 1'b0;
            out_d      = '0;
            wdata_d    = '0;
            rd_d       = '0;
        end else if (!stall) begin
            regwrite_d = EX_regwrite;
            memtoreg_d = EX_memtoreg;
            memread_d  = EX_memread;
            memwrite_d = EX_memwrite;
            in2_mux_d  = EX_in2_mux;
            out_d      = EX_out;
            wdata_d    = EX_wdata;
            rd_d       = EX_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            in2_mux_q  <= 1'b0;
            out_q      <= '0;
            wdata_q    <= '0;
            rd_q       <= '0;
        end else begin
            regwrite_q <= regwrite_d;
            memtoreg_q <= memtoreg_d;
            memread_q  <= memread_d;
            memwrite_q <= memwrite_d;
            in2_mux_q  <= in2_mux_d;
            out_q      <= out_d;
            wdata_q    <= wdata_d;
            rd_q       <= rd_d;
        end
    end

    assign MEM_regwrite = regwrite_q;
    assign MEM_memtoreg = memtoreg_q;
    assign MEM_memread  = memread_q;
    assign MEM_memwrite = memwrite_q;
    assign MEM_in2_mux  = in2_mux_q;
    assign MEM_out      = out_q;
    assign MEM_wdata    = wdata_q;
    assign MEM_rd       = rd_q;

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Directed self-checking bench for ex_mem_pipe_reg: reset, loads, stall, flush, priority.
module tb_ex_mem_pipe_reg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned RD_W   = 3;
    localparam int unsigned VEC_W  = 5 + 2 * DATA_W + RD_W;

    logic              clk;
    logic              reset;
    logic              stall;
    logic              flush;
    logic              EX_regwrite;
    logic              EX_memtoreg;
    logic              EX_memread;
    logic              EX_memwrite;
    logic              EX_in2_mux;
    logic [DATA_W-1:0] EX_out;
    logic [DATA_W-1:0] EX_wdata;
    logic [RD_W-1:0]   EX_rd;
    logic              MEM_regwrite;
    logic              MEM_memtoreg;
    logic              MEM_memread;
    logic              MEM_memwrite;
    logic              MEM_in2_mux;
    logic [DATA_W-1:0] MEM_out;
    logic [DATA_W-1:0] MEM_wdata;
    logic [RD_W-1:0]   MEM_rd;

    int n_cmp;
    int n_err;

    logic [VEC_W-1:0] obs;
    logic [VEC_W-1:0] exp_v;
    logic [VEC_W-1:0] held;

    ex_mem_pipe_reg #(
        .DATA_W(DATA_W),
        .RD_W  (RD_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .flush       (flush),
        .EX_regwrite (EX_regwrite),
        .EX_memtoreg (EX_memtoreg),
        .EX_memread  (EX_memread),
        .EX_memwrite (EX_memwrite),
        .EX_in2_mux  (EX_in2_mux),
        .EX_out      (EX_out),
        .EX_wdata    (EX_wdata),
        .EX_rd       (EX_rd),
        .MEM_regwrite(MEM_regwrite),
        .MEM_memtoreg(MEM_memtoreg),
        .MEM_memread (MEM_memread),
        .MEM_memwrite(MEM_memwrite),
        .MEM_in2_mux (MEM_in2_mux),
        .MEM_out     (MEM_out),
        .MEM_wdata   (MEM_wdata),
        .MEM_rd      (MEM_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obs = {MEM_regwrite, MEM_memtoreg, MEM_memread, MEM_memwrite, MEM_in2_mux,
                  MEM_out, MEM_wdata, MEM_rd};

    function automatic logic [VEC_W-1:0] pack(input logic rw, input logic mtr, input logic mr,
                                              input logic mw, input logic i2,
                                              input logic [DATA_W-1:0] o,
                                              input logic [DATA_W-1:0] wd,
                                              input logic [RD_W-1:0] rd);
        return {rw, mtr, mr, mw, i2, o, wd, rd};
    endfunction

    task automatic drive(input logic rw, input logic mtr, input logic mr, input logic mw,
                         input logic i2, input logic [DATA_W-1:0] o,
                         input logic [DATA_W-1:0] wd, input logic [RD_W-1:0] rd);
        EX_regwrite = rw;
        EX_memtoreg = mtr;
        EX_memread  = mr;
        EX_memwrite = mw;
        EX_in2_mux  = i2;
        EX_out      = o;
        EX_wdata    = wd;
        EX_rd       = rd;
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'hCAFE_F00D, 3'd7);
        tick();
        n_cmp++;
        if (obs !== '0) begin
            n_err++;
            $display("FAIL reset_clear: got %h want 0", obs);
        end
        reset = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h1234_5678, 32'h0000_00A5, 3'd5);
        tick();
        exp_v = pack(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h1234_5678, 32'h0000_00A5, 3'd5);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL reset_first_load: got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_plain_load();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd10, 32'd40, 3'd1);
        tick();
        exp_v = pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd10, 32'd40, 3'd1);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL plain_load: got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_store_load();
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd10, 32'd40, 3'd1);
        tick();
        exp_v = pack(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd10, 32'd40, 3'd1);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL store_load: got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_back_to_back();
        held = obs;
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd110, 32'd14, 3'd6);
        #3;
        n_cmp++;
        if (obs !== pack(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd10, 32'd40, 3'd1)) begin
            n_err++;
            $display("FAIL b2b_midcycle: got %h want %h", obs, held);
        end
        @(posedge clk);
        #1;
        exp_v = pack(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd110, 32'd14, 3'd6);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL b2b_load: got %h want %h", obs, exp_v);
        end
        // Input wiggle between edges must not leak through.
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h5555_5555, 3'd3);
        #2;
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL b2b_no_comb_path: got %h want %h", obs, exp_v);
        end
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd110, 32'd14, 3'd6);
        tick();
    endtask

    task automatic test_stall();
        exp_v = pack(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd110, 32'd14, 3'd6);
        stall = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'd999, 32'd77, 3'd2);
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL stall_hold_%0d: got %h want %h", i, obs, exp_v);
            end
        end
        stall = 1'b0;
        tick();
        exp_v = pack(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'd999, 32'd77, 3'd2);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL stall_release: got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_flush();
        flush = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 3'd7);
        tick();
        n_cmp++;
        if (obs !== '0) begin
            n_err++;
            $display("FAIL flush_bubble: got %h want 0", obs);
        end
        flush = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0042, 32'h0000_0099, 3'd4);
        tick();
        exp_v = pack(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0042, 32'h0000_0099, 3'd4);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL flush_reload: got %h want %h", obs, exp_v);
        end
        flush = 1'b1; stall = 1'b1;
        tick();
        n_cmp++;
        if (obs !== '0) begin
            n_err++;
            $display("FAIL flush_over_stall: got %h want 0", obs);
        end
        flush = 1'b0; stall = 1'b0;
        tick();
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL flush_stall_reload: got %h want %h", obs, exp_v);
        end
        reset = 1'b1; flush = 1'b1;
        tick();
        n_cmp++;
        if (obs !== '0) begin
            n_err++;
            $display("FAIL reset_flush: got %h want 0", obs);
        end
        flush = 1'b0;
    endtask

    task automatic test_reset_midstream();
        reset = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_0001, 32'h7FFF_FFFE, 3'd3);
        tick();
        exp_v = pack(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_0001, 32'h7FFF_FFFE, 3'd3);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL mid_load: got %h want %h", obs, exp_v);
        end
        reset = 1'b1; stall = 1'b1;
        tick();
        n_cmp++;
        if (obs !== '0) begin
            n_err++;
            $display("FAIL mid_reset_over_stall: got %h want 0", obs);
        end
        reset = 1'b0; stall = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0001, 32'h0000_0002, 3'd0);
        tick();
        exp_v = pack(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0001, 32'h0000_0002, 3'd0);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL mid_first_load: got %h want %h", obs, exp_v);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        test_reset();
        test_plain_load();
        test_store_load();
        test_back_to_back();
        test_stall();
        test_flush();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ex_mem_pipe_reg.md
Name:
ex_mem_pipe_reg

Overview:
EX/MEM pipeline register of the 5-stage CPU core. It captures the execute-stage ALU result, the store data, the destination register index and the MEM/WB control bits on each rising clock edge. It presents them to the memory stage one cycle later. It supports pipeline stall (hold) and flush (bubble insertion) for the hazard unit.

Parameters:
DATA_W, 32, width of the ALU result and store-data buses
RD_W, 3, width of the destination register index (8-entry register file)

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
stall  input  1  hold current contents when high (tie 0 if unused)
flush  input  1  load a bubble (all-zero) when high (tie 0 if unused)
EX_regwrite  input  1  EX-stage register-file write enable
EX_memtoreg  input  1  EX-stage writeback select (1 = memory data, 0 = ALU result)
EX_memread  input  1  EX-stage data-memory read enable
EX_memwrite  input  1  EX-stage data-memory write enable
EX_in2_mux  input  1  EX-stage ALU operand-2 select bit, forwarded for MEM-stage use
EX_out  input  DATA_W  ALU result / memory address
EX_wdata  input  DATA_W  store data (rs2 value after forwarding)
EX_rd  input  RD_W  destination register index
MEM_regwrite  output  1  registered EX_regwrite
MEM_memtoreg  output  1  registered EX_memtoreg
MEM_memread  output  1  registered EX_memread
MEM_memwrite  output  1  registered EX_memwrite
MEM_in2_mux  output  1  registered EX_in2_mux
MEM_out  output  DATA_W  registered EX_out
MEM_wdata  output  DATA_W  registered EX_wdata
MEM_rd  output  RD_W  registered EX_rd

Behaviour:
- All outputs are driven directly from flops; there is no combinational path from input to output.
- Updates occur only on the rising edge of clk. Priority is reset > flush > stall > load.
- reset=1 at an edge: every output becomes 0, including all control bits and MEM_out, MEM_wdata and MEM_rd.
- flush=1 (reset=0): every output becomes 0. This inserts a NOP, with no register write and no memory access.
- stall=1 (reset=0, flush=0): all outputs hold their previous values.
- Otherwise, every MEM_* output takes the value of its EX_* input sampled at that edge. Latency is exactly 1 cycle.
- flush and stall asserted together: flush wins.
- Reset asserted mid-stream: that edge clears everything, and the previously captured data is lost. The first load happens on the first edge with reset=0.
- Output values before the first reset edge are undefined. The system must reset before use.
- Input changes between edges have no effect on the outputs.
- No arithmetic is performed. Widths pass through unchanged with no truncation or extension.

Test Plan:
- Reset: reset=1 for one edge with arbitrary EX inputs -> all MEM_* = 0 after the edge. Deassert reset -> the next edge loads the inputs.
- Plain load: regwrite=0, memtoreg=0, memread=0, memwrite=0, out=10, wdata=40, rd=1 -> after 1 edge MEM_out=10, MEM_wdata=40, MEM_rd=1, all control bits 0.
- Store-type load: memtoreg=1, memwrite=1, out=10, wdata=40, rd=1 -> next edge MEM_memtoreg=1, MEM_memwrite=1, MEM_regwrite=0, MEM_memread=0, data unchanged.
- Back-to-back load: regwrite=1, memread=1, out=110, wdata=14, rd=6, following the previous cycle -> outputs update exactly one edge later to 110/14/6 with regwrite=1 and memread=1. Check no output changes mid-cycle.
- Stall: load out=110, then stall=1 with out=999, rd=2 for 2 edges -> MEM_out stays 110 and MEM_rd stays 6. Release stall -> 999/2 appears after the next edge.
- Flush and priority: flush=1 with memwrite=1, regwrite=1 -> all outputs 0 after the edge. Flush+stall together -> 0. Reset+flush -> 0.
